// File: rtl/shl_seq_ctrl_pkg.sv
// Shared types for the SHL sequencer: FSM encoding and the reset value of the
// round-robin pointer.
package shl_seq_ctrl_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // last_grant resets to 1 so requester 0 wins the first tie.
  localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/shl_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not
// granted last time. Purely combinational.
module shl_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_any
);

  always_comb begin
    o_any = |i_valid;
    if (&i_valid) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_valid[1];
    end
  end

endmodule

// File: rtl/shl_seq_ctrl.sv
// Arbitrates two requesters onto one external 1-bit shifter and iterates it
// amt times to produce a << amt, returning the result with a done pulse.
module shl_seq_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int AMTWIDTH  = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 req0_valid,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [AMTWIDTH-1:0]  req0_amt,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [AMTWIDTH-1:0]  req1_amt,
  output logic                 req1_ready,
  output logic [DATAWIDTH-1:0] shl_a,
  output logic                 shl_sh_amt,
  input  logic [DATAWIDTH-1:0] shl_d,
  output logic [DATAWIDTH-1:0] d,
  output logic                 done0,
  output logic                 done1,
  output logic                 busy,
  output logic [1:0]           o_dbg_state
);
  import shl_seq_ctrl_pkg::*;

  // Handshake: a request is taken on a rising edge where reqN_valid and
  // reqN_ready are both high; ready is only ever high in IDLE out of reset,
  // and the requester must hold valid/a/amt stable until then.

  state_t                r_state, w_state_nxt;
  logic [DATAWIDTH-1:0]  r_acc, w_acc_nxt;
  logic [AMTWIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_owner, w_owner_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic [DATAWIDTH-1:0]  r_d, w_d_nxt;
  logic                  r_done0, w_done0_nxt;
  logic                  r_done1, w_done1_nxt;
  logic                  w_sh;
  logic                  w_grant, w_any, w_idle;
  logic [AMTWIDTH-1:0]   w_amt_sel;

  shl_rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  assign w_idle     = Rst & (r_state == ST_IDLE);
  assign req0_ready = w_idle & req0_valid & ~w_grant;
  assign req1_ready = w_idle & req1_valid & w_grant;
  assign w_amt_sel  = w_grant ? req1_amt : req0_amt;

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_d_nxt          = r_d;
    w_done0_nxt      = 1'b0;
    w_done1_nxt      = 1'b0;
    w_sh             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_acc_nxt        = w_grant ? req1_a : req0_a;
          w_cnt_nxt        = w_amt_sel;
          w_owner_nxt      = w_grant;
          w_last_grant_nxt = w_grant;
          w_state_nxt      = (w_amt_sel == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Exit at cnt==1 so the count never wraps below zero.
        w_sh      = 1'b1;
        w_acc_nxt = shl_d;
        w_cnt_nxt = r_cnt - AMTWIDTH'(1);
        if (r_cnt == AMTWIDTH'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_d_nxt     = r_acc;
        w_done0_nxt = ~r_owner;
        w_done1_nxt = r_owner;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= LAST_GRANT_RST;
      r_d          <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_d          <= w_d_nxt;
      r_done0      <= w_done0_nxt;
      r_done1      <= w_done1_nxt;
    end
  end

  assign shl_a       = r_acc;
  assign shl_sh_amt  = w_sh;
  assign d           = r_d;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign busy        = (r_state == ST_SHIFT) | (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shl_seq_ctrl.sv
// Bench for shl_seq_ctrl: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the sequencer.
module tb_shl_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req1_a;
  logic [2:0] req0_amt, req1_amt;
  logic       req0_ready, req1_ready;
  logic [7:0] shl_a, shl_d, d;
  logic       shl_sh_amt, done0, done1, busy;
  logic [1:0] dbg_state;

  // Second instance with a 4-bit amount to exercise amt >= DATAWIDTH.
  logic       v4;
  logic [7:0] a4, shl_a4, shl_d4, d4;
  logic [3:0] amt4;
  logic       rdy4, r1rdy4, sh4, done0_4, done1_4, busy4;
  logic [1:0] st4;

  always #5 Clk = ~Clk;

  // External 1-bit shifter next to each DUT.
  assign shl_d  = shl_sh_amt ? {shl_a[6:0], 1'b0} : shl_a;
  assign shl_d4 = sh4 ? {shl_a4[6:0], 1'b0} : shl_a4;

  shl_seq_ctrl #(.DATAWIDTH(8), .AMTWIDTH(3)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .shl_a(shl_a), .shl_sh_amt(shl_sh_amt), .shl_d(shl_d),
    .d(d), .done0(done0), .done1(done1), .busy(busy), .o_dbg_state(dbg_state)
  );

  shl_seq_ctrl #(.DATAWIDTH(8), .AMTWIDTH(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(v4), .req0_a(a4), .req0_amt(amt4), .req0_ready(rdy4),
    .req1_valid(1'b0), .req1_a(8'h00), .req1_amt(4'h0), .req1_ready(r1rdy4),
    .shl_a(shl_a4), .shl_sh_amt(sh4), .shl_d(shl_d4),
    .d(d4), .done0(done0_4), .done1(done1_4), .busy(busy4), .o_dbg_state(st4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: m_left counts edges until the done pulse is visible.
  bit         m_live = 1'b0;
  int         m_left;
  logic [7:0] m_a, m_res, m_d, m_hold;
  logic [2:0] m_amt;
  logic       m_owner, m_last, m_done0, m_done1, m_g;
  logic [15:0] m_tmp;

  always @(posedge Clk) begin
    if (!Rst) begin
      m_live = 1'b1; m_left = 0; m_d = 8'h00; m_hold = 8'h00; m_a = 8'h00; m_amt = 3'd0;
      m_res = 8'h00; m_done0 = 1'b0; m_done1 = 1'b0; m_last = 1'b1; m_owner = 1'b0;
    end else if (m_live) begin
      m_done0 = 1'b0;
      m_done1 = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_d = m_res; m_hold = m_res;
          m_done0 = !m_owner; m_done1 = m_owner;
        end
      end else if (req0_valid || req1_valid) begin
        m_g     = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        m_a     = m_g ? req1_a : req0_a;
        m_amt   = m_g ? req1_amt : req0_amt;
        m_tmp   = {8'h00, m_a} << m_amt;
        m_res   = m_tmp[7:0];
        m_left  = int'(m_amt) + 1;
        m_owner = m_g;
        m_last  = m_g;
      end
    end
  end

  logic        c_g, c_r0, c_r1;
  logic [15:0] c_tmp;
  logic [7:0]  c_acc;
  logic [1:0]  c_st;

  always @(negedge Clk) begin
    if (m_live) begin
      c_g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      c_r0 = Rst && (m_left == 0) && req0_valid && !c_g;
      c_r1 = Rst && (m_left == 0) && req1_valid && c_g;
      c_tmp = {8'h00, m_a} << (int'(m_amt) + 1 - m_left);
      c_acc = (m_left >= 1) ? c_tmp[7:0] : m_hold;
      c_st  = (m_left == 0) ? 2'd0 : ((m_left >= 2) ? 2'd1 : 2'd2);
      chk("req0_ready", req0_ready, c_r0);
      chk("req1_ready", req1_ready, c_r1);
      chk("busy", busy, m_left >= 1);
      chk("shl_sh_amt", shl_sh_amt, m_left >= 2);
      chk("shl_a", shl_a, c_acc);
      chk("d", d, m_d);
      chk("done0", done0, m_done0);
      chk("done1", done1, m_done1);
      chk("state", dbg_state, c_st);
    end
  end

  task automatic issue(input int r, input logic [7:0] a, input logic [2:0] amt, input string tag);
    bit got;
    got = 1'b0;
    @(posedge Clk); #1;
    if (r == 0) begin req0_valid = 1'b1; req0_a = a; req0_amt = amt; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_amt = amt; end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if ((r == 0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
    end
    chk({tag, " accept"}, got, 1'b1);
    @(posedge Clk); #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_done(input int amt, input logic owner, input logic [7:0] exp_d, input string tag);
    bit seen;
    int nsh;
    seen = 1'b0;
    nsh  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (shl_sh_amt) nsh++;
      if (done0 || done1) begin
        seen = 1'b1;
        chk({tag, " latency"}, i, amt + 1);
        chk({tag, " owner"}, done1, owner);
        chk({tag, " d"}, d, exp_d);
        chk({tag, " model d"}, m_d, exp_d);
        break;
      end
    end
    chk({tag, " done seen"}, seen, 1'b1);
    chk({tag, " shifts"}, nsh, amt);
  endtask

  int  gr[4], acc_c[4], done_c[4];
  int  na, nd, nsh4, ndone;
  bit  seen4, a0, a1;

  initial begin
    Rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h03; req0_amt = 3'd3;
    req1_valid = 1'b0; req1_a = 8'h00; req1_amt = 3'd0;
    v4 = 1'b0; a4 = 8'h00; amt4 = 4'd0;

    // 1: reset holds everything quiet even with a pending request.
    repeat (2) begin
      @(negedge Clk);
      chk("t1 ready in reset", req0_ready, 1'b0);
      chk("t1 d in reset", d, 8'h00);
      chk("t1 done in reset", {done1, done0}, 2'b00);
      chk("t1 busy in reset", busy, 1'b0);
    end
    @(posedge Clk); #1; Rst = 1'b1;
    @(negedge Clk);
    chk("t1 ready after reset", req0_ready, 1'b1);
    @(posedge Clk); #1; req0_valid = 1'b0;

    // 2: 3 << 3.
    wait_done(3, 1'b0, 8'h18, "t2");

    // 3: zero-amount passthrough.
    issue(1, 8'hA5, 3'd0, "t3");
    wait_done(0, 1'b1, 8'hA5, "t3");

    // 4: continuous contention alternates grants.
    @(posedge Clk); #1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_amt = 3'd1;
    req1_valid = 1'b1; req1_a = 8'h22; req1_amt = 3'd1;
    na = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if ((done0 || done1) && nd < 4) begin done_c[nd] = cyc; nd++; end
      if ((req0_ready || req1_ready) && na < 4) begin
        gr[na] = int'(req1_ready); acc_c[na] = cyc + 1; na++;
        if (na == 4) begin @(posedge Clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; end
      end
    end
    chk("t4 accepts", na, 4);
    chk("t4 dones", nd, 4);
    for (int i = 0; i < na; i++) chk("t4 grant order", gr[i], i % 2);
    for (int i = 0; i + 1 < na; i++) chk("t4 accept spacing", acc_c[i+1] - acc_c[i], 3);
    for (int i = 0; i < na && i < nd; i++) chk("t4 done delay", done_c[i] - acc_c[i], 2);

    // 5: MSBs fall off; amt beyond width clears the operand.
    issue(0, 8'hFF, 3'd7, "t5a");
    wait_done(7, 1'b0, 8'h80, "t5a");

    @(posedge Clk); #1; v4 = 1'b1; a4 = 8'hFF; amt4 = 4'd9;
    seen4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (rdy4) begin seen4 = 1'b1; break; end
    end
    chk("t5b accept", seen4, 1'b1);
    @(posedge Clk); #1; v4 = 1'b0;
    seen4 = 1'b0; nsh4 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (sh4) nsh4++;
      if (done0_4 || done1_4) begin
        seen4 = 1'b1;
        chk("t5b latency", i, 10);
        chk("t5b d", d4, 8'h00);
        chk("t5b owner", done1_4, 1'b0);
        break;
      end
    end
    chk("t5b done seen", seen4, 1'b1);
    chk("t5b shifts", nsh4, 9);

    // 6: reset mid-shift aborts silently; a fresh op then completes.
    issue(0, 8'h5A, 3'd5, "t6");
    repeat (2) @(negedge Clk);
    @(posedge Clk); #1; Rst = 1'b0;
    @(posedge Clk); #1;
    chk("t6 state after reset", dbg_state, 2'd0);
    chk("t6 busy after reset", busy, 1'b0);
    Rst = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge Clk);
      if (done0 || done1) ndone++;
    end
    chk("t6 no done after abort", ndone, 0);
    issue(0, 8'h11, 3'd2, "t6b");
    wait_done(2, 1'b0, 8'h44, "t6b");

    // Random traffic with withdrawals and occasional resets.
    repeat (3000) begin
      @(negedge Clk);
      a0 = req0_ready; a1 = req1_ready;
      @(posedge Clk); #1;
      Rst = ($urandom_range(0, 299) != 0);
      if (req0_valid && (a0 || $urandom_range(0, 19) == 0)) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_a = 8'($urandom); req0_amt = 3'($urandom_range(0, 7));
      end
      if (req1_valid && (a1 || $urandom_range(0, 19) == 0)) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_a = 8'($urandom); req1_amt = 3'($urandom_range(0, 7));
      end
    end
    Rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
